dispatch_buffer: RTL

Dispatch-stage buffer between rename and `issue_queue`: accepts up to DISPATCH_WIDTH renamed micro-ops per cycle, computes each operand's initial ready bit (p1/p2) from a physical-register busy table, and holds micro-ops in a small circular FIFO. Buffered entries snoop the wakeup ports so their ready bits stay current. Up to DISPATCH_WIDTH micro-ops per cycle are presented to `issue_queue` in the `issue_slot_io` field format. It owns the busy table for the whole core.

---
 rtl/dispatch_buffer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dispatch_buffer.sv
// dispatch_buffer: rename-to-issue dispatch FIFO.
// Computes initial operand ready bits from the core-wide physical register
// busy table, keeps buffered ready bits current by snooping wakeups, and
// presents up to DISPATCH_WIDTH micro-ops per cycle to the issue queue.
module dispatch_buffer #(
  parameter int DISPATCH_WIDTH   = 2,
  parameter int NUM_WAKEUP_PORTS = 2,
  parameter int DEPTH            = 8,
  parameter int NUM_PREGS        = 128
) (
  input  logic                               i_clk,
  input  logic                               i_reset,      // active-low, asynchronous
  input  logic                               i_flush,
  input  logic [DISPATCH_WIDTH-1:0]          i_ren_valid,
  input  logic [DISPATCH_WIDTH*7-1:0]        i_ren_src_id1,
  input  logic [DISPATCH_WIDTH*7-1:0]        i_ren_src_id2,
  input  logic [DISPATCH_WIDTH-1:0]          i_ren_v1,
  input  logic [DISPATCH_WIDTH-1:0]          i_ren_v2,
  input  logic [DISPATCH_WIDTH*7-1:0]        i_ren_pdst,
  input  logic [DISPATCH_WIDTH-1:0]          i_ren_pdst_v,
  input  logic [DISPATCH_WIDTH-1:0]          i_ren_ctrl,
  output logic                               o_ren_ready,
  input  logic [NUM_WAKEUP_PORTS-1:0]        i_wk_valid,
  input  logic [NUM_WAKEUP_PORTS*7-1:0]      i_wk_pdst,
  output logic [DISPATCH_WIDTH-1:0]          o_iq_valid,
  output logic [DISPATCH_WIDTH*7-1:0]        o_iq_src_id1,
  output logic [DISPATCH_WIDTH-1:0]          o_iq_p1,
  output logic [DISPATCH_WIDTH-1:0]          o_iq_v1,
  output logic [DISPATCH_WIDTH*7-1:0]        o_iq_src_id2,
  output logic [DISPATCH_WIDTH-1:0]          o_iq_p2,
  output logic [DISPATCH_WIDTH-1:0]          o_iq_v2,
  output logic [DISPATCH_WIDTH-1:0]          o_iq_ctrl,
  input  logic                               i_iq_ready
);

  localparam int TW = 7;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] L_WIDTH = CW'(DISPATCH_WIDTH);

  typedef struct packed {
    logic [TW-1:0] src1;
    logic          p1;
    logic          v1;
    logic [TW-1:0] src2;
    logic          p2;
    logic          v2;
    logic          ctrl;
  } entry_t;

  entry_t                 r_mem [DEPTH];
  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_tail;
  logic [CW-1:0]          r_count;
  logic [NUM_PREGS-1:0]   r_busy;

  logic [CW-1:0]          w_enq_n;
  logic [CW-1:0]          w_deq_n;
  logic                   w_enq;
  logic [NUM_PREGS-1:0]   w_busy_next;
  entry_t                 w_new [DISPATCH_WIDTH];

  // True when any valid wakeup port broadcasts this tag in the current cycle.
  function automatic logic wk_hit(input logic [TW-1:0] tag,
                                  input logic [NUM_WAKEUP_PORTS-1:0] vld,
                                  input logic [NUM_WAKEUP_PORTS*TW-1:0] pd);
    logic h;
    h = 1'b0;
    for (int k = 0; k < NUM_WAKEUP_PORTS; k++)
      if (vld[k] && pd[k*TW +: TW] == tag) h = 1'b1;
    return h;
  endfunction

  // Accept/dequeue sizing; ren_ready looks only at registered count and flush.
  always_comb begin
    w_enq_n = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      w_enq_n = w_enq_n + CW'(i_ren_valid[i]);
    o_ren_ready = !i_flush && ((L_DEPTH - r_count) >= L_WIDTH);
    w_enq       = o_ren_ready && (|i_ren_valid);
    w_deq_n     = '0;
    if (i_iq_ready)
      w_deq_n = (r_count < L_WIDTH) ? r_count : L_WIDTH;
  end

  // Build incoming entries with initial ready bits, masking intra-group dependencies.
  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      w_new[i].src1 = i_ren_src_id1[i*TW +: TW];
      w_new[i].src2 = i_ren_src_id2[i*TW +: TW];
      w_new[i].v1   = i_ren_v1[i];
      w_new[i].v2   = i_ren_v2[i];
      w_new[i].ctrl = i_ren_ctrl[i];
      w_new[i].p1   = !i_ren_v1[i] || (w_new[i].src1 == '0) || !r_busy[w_new[i].src1]
                      || wk_hit(w_new[i].src1, i_wk_valid, i_wk_pdst);
      w_new[i].p2   = !i_ren_v2[i] || (w_new[i].src2 == '0) || !r_busy[w_new[i].src2]
                      || wk_hit(w_new[i].src2, i_wk_valid, i_wk_pdst);
      for (int j = 0; j < i; j++) begin
        if (i_ren_valid[j] && i_ren_pdst_v[j]) begin
          if (i_ren_pdst[j*TW +: TW] == w_new[i].src1) w_new[i].p1 = 1'b0;
          if (i_ren_pdst[j*TW +: TW] == w_new[i].src2) w_new[i].p2 = 1'b0;
        end
      end
    end
  end

  // Busy table update: wakeups clear, accepted destinations set (set wins), tag 0 never busy.
  always_comb begin
    w_busy_next = r_busy;
    for (int k = 0; k < NUM_WAKEUP_PORTS; k++)
      if (i_wk_valid[k]) w_busy_next[i_wk_pdst[k*TW +: TW]] = 1'b0;
    if (w_enq)
      for (int i = 0; i < DISPATCH_WIDTH; i++)
        if (i_ren_valid[i] && i_ren_pdst_v[i]) w_busy_next[i_ren_pdst[i*TW +: TW]] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // Pointers, occupancy and busy table.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (i_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + PW'(w_deq_n);
        if (w_enq) r_tail <= r_tail + PW'(w_enq_n);
        r_count <= r_count + (w_enq ? w_enq_n : '0) - w_deq_n;
      end
    end
  end

  // Entry storage: snoop wakeups into every slot, then write accepted lanes at tail.
  // NOTE: the payload array has no reset; occupancy is tracked by r_count and
  // outputs are gated by it, so stale slot contents are never observed.
  always_ff @(posedge i_clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (r_mem[e].v1 && wk_hit(r_mem[e].src1, i_wk_valid, i_wk_pdst)) r_mem[e].p1 <= 1'b1;
      if (r_mem[e].v2 && wk_hit(r_mem[e].src2, i_wk_valid, i_wk_pdst)) r_mem[e].p2 <= 1'b1;
    end
    if (w_enq)
      for (int i = 0; i < DISPATCH_WIDTH; i++)
        if (i_ren_valid[i]) r_mem[r_tail + PW'(i)] <= w_new[i];
  end

  // Present head entries to the issue queue with same-cycle wakeup bypass on ready bits.
  always_comb begin
    o_iq_valid   = '0;
    o_iq_src_id1 = '0;
    o_iq_p1      = '0;
    o_iq_v1      = '0;
    o_iq_src_id2 = '0;
    o_iq_p2      = '0;
    o_iq_v2      = '0;
    o_iq_ctrl    = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (r_count > CW'(i)) begin
        o_iq_valid[i]            = 1'b1;
        o_iq_src_id1[i*TW +: TW] = r_mem[r_head + PW'(i)].src1;
        o_iq_src_id2[i*TW +: TW] = r_mem[r_head + PW'(i)].src2;
        o_iq_v1[i]               = r_mem[r_head + PW'(i)].v1;
        o_iq_v2[i]               = r_mem[r_head + PW'(i)].v2;
        o_iq_ctrl[i]             = r_mem[r_head + PW'(i)].ctrl;
        o_iq_p1[i] = r_mem[r_head + PW'(i)].p1 || (r_mem[r_head + PW'(i)].v1
                     && wk_hit(r_mem[r_head + PW'(i)].src1, i_wk_valid, i_wk_pdst));
        o_iq_p2[i] = r_mem[r_head + PW'(i)].p2 || (r_mem[r_head + PW'(i)].v2
                     && wk_hit(r_mem[r_head + PW'(i)].src2, i_wk_valid, i_wk_pdst));
      end
    end
  end

endmodule
